// File: rtl/popcount_residual_act_if.sv
// Handshake bundle between the popcount stage, the residual
// activation block and the next layer's input buffer.
interface popcount_residual_act_if #(
  parameter int popcount_width = 16,
  parameter int acc_width      = 24,
  parameter int act_levels     = 2,
  parameter int gamma_width    = 16
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic signed [popcount_width-1:0]     in_data;
  logic signed [acc_width-1:0]          threshold;
  logic [act_levels*gamma_width-1:0]    act_gamma;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [act_levels-1:0]                out_bits;
  logic signed [acc_width-1:0]          out_acc;
  logic                                 busy;

  modport master (
    output in_valid, in_data, threshold, act_gamma, out_ready,
    input  in_ready, out_valid, out_bits, out_acc, busy
  );

  modport slave (
    input  in_valid, in_data, threshold, act_gamma, out_ready,
    output in_ready, out_valid, out_bits, out_acc, busy
  );
endinterface

// File: rtl/popcount_residual_act.sv
// Accumulates popcount beats into a neuron, subtracts the threshold
// and emits multi-level residual binarized activation bits.
module popcount_residual_act #(
  parameter int popcount_width = 16,
  parameter int acc_width      = 24,
  parameter int syn_fold       = 4,
  parameter int act_levels     = 2,
  parameter int gamma_width    = 16
) (
  input  logic clk,
  input  logic rst,
  popcount_residual_act_if.slave bus
);
  localparam int PW = popcount_width;
  localparam int AW = acc_width;
  localparam int GW = gamma_width;
  localparam int AL = act_levels;
  localparam int CW = (syn_fold > 1) ? $clog2(syn_fold) : 1;
  localparam int LW = (AL > 1) ? $clog2(AL) : 1;
  localparam int MW = (AW > GW) ? AW : GW;
  // Headroom so gamma steps never wrap the residual.
  localparam int RW = MW + LW + 2;

  typedef enum logic [1:0] {
    S_ACCUM, S_SUB, S_BIN, S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [LW-1:0]         r_lvl;
  logic signed [AW-1:0]  r_acc;
  logic signed [AW-1:0]  r_thr;
  logic [AL*GW-1:0]      r_gam;
  logic signed [RW-1:0]  r_res;
  logic [AL-1:0]         r_bits;

  logic                  w_in_rdy;
  logic                  w_in_hs;
  logic                  w_last_beat;
  logic                  w_last_lvl;
  logic signed [AW-1:0]  w_base;
  logic signed [AW:0]    w_sum;
  logic signed [AW-1:0]  w_sat;
  logic signed [RW-1:0]  w_diff;
  logic [GW-1:0]         w_g;
  logic signed [RW-1:0]  w_gam;
  logic signed [RW-1:0]  w_res_nxt;

  assign w_in_rdy    = (r_state == S_ACCUM) && !rst;
  assign w_in_hs     = bus.in_valid && w_in_rdy;
  assign w_last_beat = (r_cnt == CW'(syn_fold - 1));
  assign w_last_lvl  = (r_lvl == LW'(AL - 1));

  assign w_base = (r_cnt == '0) ? '0 : r_acc;
  assign w_sum  = {w_base[AW-1], w_base}
                + {{(AW+1-PW){bus.in_data[PW-1]}}, bus.in_data};

  always_comb begin
    w_sat = w_sum[AW-1:0];
    if (w_sum[AW] != w_sum[AW-1]) begin
      w_sat = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                        : {1'b0, {(AW-1){1'b1}}};
    end
  end

  assign w_diff = {{(RW-AW){r_acc[AW-1]}}, r_acc}
                - {{(RW-AW){r_thr[AW-1]}}, r_thr};
  assign w_g    = r_gam[r_lvl*GW +: GW];
  assign w_gam  = {{(RW-GW){w_g[GW-1]}}, w_g};
  assign w_res_nxt = r_res[RW-1] ? (r_res + w_gam)
                                 : (r_res - w_gam);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ACCUM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ACCUM: if (w_in_hs && w_last_beat) w_next = S_SUB;
      S_SUB:   w_next = S_BIN;
      S_BIN:   if (w_last_lvl) w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_ACCUM;
      default: w_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_lvl  <= '0;
      r_acc  <= '0;
      r_thr  <= '0;
      r_gam  <= '0;
      r_res  <= '0;
      r_bits <= '0;
    end else begin
      unique case (r_state)
        S_ACCUM: begin
          if (w_in_hs) begin
            r_acc <= w_sat;
            r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
              r_thr <= bus.threshold;
              r_gam <= bus.act_gamma;
            end
          end
        end
        S_SUB: begin
          r_res <= w_diff;
          r_lvl <= '0;
        end
        S_BIN: begin
          r_bits[r_lvl] <= ~r_res[RW-1];
          r_res         <= w_res_nxt;
          r_lvl         <= w_last_lvl ? '0 : r_lvl + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = (r_state == S_OUT) && !rst;
  assign bus.out_bits  = rst ? '0 : r_bits;
  assign bus.out_acc   = rst ? '0 : r_acc;
  assign bus.busy      = !rst
    && !((r_state == S_ACCUM) && (r_cnt == '0));
endmodule

// File: tb/tb_popcount_residual_act.sv
// Table-driven and randomized checks of popcount_residual_act,
// with a 16-bit accumulator twin run in lockstep for saturation.
module tb_popcount_residual_act;
  localparam int SF  = 4;
  localparam int AL  = 2;
  localparam int AW  = 24;
  localparam int AWS = 16;
  localparam int LAT = AL + 2;

  typedef struct {
    string      nm;
    int         b[SF];
    int         thr;
    int         g0;
    int         g1;
    logic [1:0] xb;
    longint     xacc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  popcount_residual_act_if #(
    .popcount_width(16), .acc_width(AW),
    .act_levels(AL), .gamma_width(16)
  ) mb ();

  popcount_residual_act_if #(
    .popcount_width(16), .acc_width(AWS),
    .act_levels(AL), .gamma_width(16)
  ) sb ();

  assign sb.in_valid  = mb.in_valid;
  assign sb.in_data   = mb.in_data;
  assign sb.threshold = mb.threshold[AWS-1:0];
  assign sb.act_gamma = mb.act_gamma;
  assign sb.out_ready = mb.out_ready;

  popcount_residual_act #(
    .popcount_width(16), .acc_width(AW), .syn_fold(SF),
    .act_levels(AL), .gamma_width(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(mb)
  );

  popcount_residual_act #(
    .popcount_width(16), .acc_width(AWS), .syn_fold(SF),
    .act_levels(AL), .gamma_width(16)
  ) u_sat (
    .clk(clk), .rst(rst), .bus(sb)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic with clamping.
  function automatic void model(
    input int b[SF], input int thr, input int g0, input int g1,
    input int aw, output longint acc, output logic [1:0] bits);
    longint hi, lo, t, r;
    longint g[AL];
    hi  = (longint'(1) << (aw - 1)) - 1;
    lo  = -(longint'(1) << (aw - 1));
    acc = 0;
    for (int i = 0; i < SF; i++) begin
      acc += b[i];
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    t = longint'(thr) & ((longint'(1) << aw) - 1);
    if (t > hi) t -= (longint'(1) << aw);
    r = acc - t;
    g[0] = g0;
    g[1] = g1;
    bits = '0;
    for (int k = 0; k < AL; k++) begin
      bits[k] = (r >= 0);
      r = bits[k] ? r - g[k] : r + g[k];
    end
  endfunction

  function automatic vec_t mk(input string nm, input int a0,
    input int a1, input int a2, input int a3, input int thr,
    input int g0, input int g1, input logic [1:0] xb,
    input longint xacc);
    vec_t v;
    v.nm = nm;
    v.b[0] = a0; v.b[1] = a1; v.b[2] = a2; v.b[3] = a3;
    v.thr = thr; v.g0 = g0; v.g1 = g1;
    v.xb = xb; v.xacc = xacc;
    return v;
  endfunction

  task automatic junk();
    mb.in_data   = 16'($urandom);
    mb.threshold = 24'($urandom);
    mb.act_gamma = 32'($urandom);
  endtask

  task automatic beat(input int d, input int thr, input int g0,
                      input int g1, input bit first);
    int n = 0;
    @(negedge clk);
    junk();
    mb.in_valid = 1'b1;
    mb.in_data  = 16'(d);
    if (first) begin
      mb.threshold = 24'(thr);
      mb.act_gamma = {16'(g1), 16'(g0)};
    end
    while (!mb.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("in_ready_timeout", 0, 1);
      mb.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 mb.in_valid = 1'b0;
    junk();
  endtask

  task automatic run_neuron(input string nm, input int b[SF],
    input int thr, input int g0, input int g1, input int gap,
    input int hold, input bit early, input bit jv,
    input bit hand, input logic [1:0] xb, input longint xacc);
    longint     eacc, sacc;
    logic [1:0] eb, sbits;
    int         lat;
    model(b, thr, g0, g1, AW, eacc, eb);
    model(b, thr, g0, g1, AWS, sacc, sbits);
    if (hand) begin
      eacc = xacc;
      eb   = xb;
    end
    for (int i = 0; i < SF; i++) begin
      repeat (gap) begin
        @(negedge clk);
        junk();
      end
      beat(b[i], thr, g0, g1, i == 0);
    end
    if (early) mb.out_ready = 1'b1;
    if (jv) mb.in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mb.out_valid && lat < 20);
    if (!mb.out_valid) begin
      chk({nm, "_out_valid_timeout"}, 0, 1);
      mb.out_ready = 1'b0;
      mb.in_valid  = 1'b0;
      return;
    end
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_acc"}, mb.out_acc, eacc);
    chk({nm, "_bits"}, mb.out_bits, eb);
    chk({nm, "_sat_acc"}, sb.out_acc, sacc);
    chk({nm, "_sat_bits"}, sb.out_bits, sbits);
    chk({nm, "_in_ready_out"}, mb.in_ready, 0);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, mb.out_valid, 1);
        chk({nm, "_hold_acc"}, mb.out_acc, eacc);
        chk({nm, "_hold_bits"}, mb.out_bits, eb);
        chk({nm, "_hold_in_ready"}, mb.in_ready, 0);
      end
      mb.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    mb.out_ready = 1'b0;
    mb.in_valid  = 1'b0;
    @(negedge clk);
    chk({nm, "_valid_drop"}, mb.out_valid, 0);
    chk({nm, "_idle_busy"}, mb.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   b[SF];
    logic signed [15:0] t16;
    logic signed [23:0] t24;
    int   thr, g0, g1;

    tbl[0] = mk("basic", 10, 20, -5, 7, 12, 8, 4, 2'b11, 32);
    tbl[1] = mk("negative", -3, -3, -3, -3, 0, 8, 4, 2'b00, -12);
    tbl[2] = mk("zero_res", 5, 5, 0, 0, 10, 3, 5, 2'b01, 10);
    tbl[3] = mk("gamma0", 1, 1, 1, -10, -7, 0, 6, 2'b11, -7);
    tbl[4] = mk("minbeats", -32768, -32768, -32768, -32768,
                100, -5, 1000, 2'b00, -131072);
    tbl[5] = mk("small", 100, 0, 0, 0, -50, 200, 100, 2'b01, 100);

    rst = 1'b1;
    mb.in_valid  = 1'b0;
    mb.out_ready = 1'b0;
    junk();
    @(negedge clk);
    chk("reset_in_ready", mb.in_ready, 0);
    chk("reset_out_valid", mb.out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_acc", mb.out_acc, 0);
    chk("reset_out_bits", mb.out_bits, 0);
    chk("reset_busy", mb.busy, 0);
    chk("reset_ready_after", mb.in_ready, 1);

    foreach (tbl[i]) begin
      run_neuron(tbl[i].nm, tbl[i].b, tbl[i].thr, tbl[i].g0,
                 tbl[i].g1, 0, 0, 1'b0, 1'b0, 1'b1,
                 tbl[i].xb, tbl[i].xacc);
    end

    b = '{32767, 32767, 32767, 32767};
    run_neuron("sat_pos", b, 0, 1, 1, 0, 0, 1'b0, 1'b0,
               1'b1, 2'b11, 131068);
    b = '{-32768, -32768, -32768, -32768};
    run_neuron("sat_neg", b, 0, 1, 1, 0, 0, 1'b0, 1'b0,
               1'b1, 2'b00, -131072);

    b = '{3, -1, 4, 1};
    run_neuron("bp", b, 2, 1, 9, 1, 5, 1'b0, 1'b1,
               1'b1, 2'b11, 7);
    b = '{1, 2, 3, 4};
    run_neuron("bp_next", b, 20, 2, 3, 0, 0, 1'b0, 1'b0,
               1'b1, 2'b00, 10);
    b = '{-1, -1, -1, -1};
    run_neuron("early_rdy", b, -4, 5, 5, 0, 0, 1'b1, 1'b0,
               1'b1, 2'b01, -4);

    beat(100, 5, 1, 1, 1'b1);
    beat(200, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", mb.in_ready, 0);
    chk("midrst_out_valid", mb.out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", mb.busy, 0);
    chk("midrst_acc", mb.out_acc, 0);
    b = '{1, 1, 1, 1};
    run_neuron("rst_fresh", b, 0, 1, 1, 0, 0, 1'b0, 1'b0,
               1'b1, 2'b11, 4);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < SF; i++) begin
        t16 = 16'($urandom);
        if ($urandom_range(0, 7) == 0) t16 = 16'sh7fff;
        if ($urandom_range(0, 7) == 0) t16 = -16'sh8000;
        b[i] = t16;
      end
      t24 = 24'($urandom);
      if ($urandom_range(0, 1) == 0) t24 = 24'($signed(t16));
      thr = t24;
      t16 = 16'($urandom);
      g0  = t16;
      t16 = 16'($urandom);
      g1  = t16;
      if ($urandom_range(0, 5) == 0) g0 = 0;
      run_neuron("rand", b, thr, g0, g1,
                 $urandom_range(0, 2), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 1'b0, 2'b00, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
